mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle main control state machine for the 16-bit MIPS-style core. It sequences instruction fetch, decode, execute, memory access and write-back, and drives every datapath enable. It also supplies the 2-bit sig_ALUop to the ALU control decoder, which combines it with the 4-bit function field. Memory accesses use a ready handshake so variable-latency memory stalls the sequence.

Parameters:
OPW, 4, opcode field width (instr[15:12])
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before raising sig_mem_err

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  OPW  opcode from the instruction register
mem_ready  input  1  memory has completed the current read/write this cycle
run  input  1  leave HALT and restart fetch (pulse)
sig_pc_write  output  1  unconditional PC load
sig_pc_write_cond  output  1  PC load if ALU zero (beq)
sig_IorD  output  1  0 = PC addresses memory, 1 = ALUOut
sig_mem_read  output  1  memory read request
sig_mem_write  output  1  memory write request
sig_ir_write  output  1  instruction register load
sig_mem_to_reg  output  1  write-back source 1 = MDR, 0 = ALUOut
sig_reg_write  output  1  register file write enable
sig_reg_dst  output  1  1 = rd, 0 = rt
sig_ALUsrcA  output  1  0 = PC, 1 = register A
sig_ALUsrcB  output  2  00 = B, 01 = const 1, 10 = sign-ext imm, 11 = zero-ext imm
sig_ALUop  output  2  00 = func-driven, 01 = and, 10 = sub, 11 = add
sig_pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
sig_state  output  4  current state encoding, for debug
sig_illegal_op  output  1  sticky; set on an undefined opcode
sig_mem_err  output  1  sticky; set on a memory timeout

Behaviour:
- Reset (async, reset_n = 0): state = FETCH; every output is 0; sticky flags cleared; wait counter = 0.
- Opcodes: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 andi, 0110 j, 1111 halt. All others are illegal.
- Outputs are Moore: decoded from the current state only. Any signal not listed for a state is 0.
- States and assertions:
  - FETCH(0): mem_read, IorD = 0, ALUsrcA = 0, ALUsrcB = 01, ALUop = 11. ir_write and pc_write are asserted only in the cycle mem_ready = 1. Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE(1): ALUsrcA = 0, ALUsrcB = 10, ALUop = 11 (branch target precompute). Next state by opcode: lw/sw/addi → MEMADR; R → EXEC_R; andi → EXEC_I; beq → BRANCH; j → JUMP; halt → HALT; illegal → set sig_illegal_op, then FETCH.
  - MEMADR(2): ALUsrcA = 1, ALUsrcB = 10, ALUop = 11. Next: lw → MEMRD, sw → MEMWR, addi → WB_I.
  - MEMRD(3): mem_read, IorD = 1. Hold until mem_ready, then go to WB_MEM.
  - WB_MEM(4): reg_write, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
  - MEMWR(5): mem_write, IorD = 1. Hold until mem_ready, then go to FETCH.
  - EXEC_R(6): ALUsrcA = 1, ALUsrcB = 00, ALUop = 00. Next: WB_R.
  - WB_R(7): reg_write, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
  - EXEC_I(8): ALUsrcA = 1, ALUsrcB = 11, ALUop = 01. Next: WB_I.
  - WB_I(9): reg_write, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
  - BRANCH(10): ALUsrcA = 1, ALUsrcB = 00, ALUop = 10, pc_write_cond, pc_source = 01. Next: FETCH.
  - JUMP(11): pc_write, pc_source = 10. Next: FETCH.
  - HALT(12): all enables 0. When run = 1, go to FETCH.
- Memory handshake:
  - The wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready = 0 there (saturates at MEM_TIMEOUT).
  - On reaching MEM_TIMEOUT: set sig_mem_err and go to HALT; the aborted write/read is dropped.
  - mem_ready outside a memory state is ignored.
- Latency: R/addi/andi = 4 cycles, lw = 5, sw = 4, beq = 3, j = 3, each with zero-wait memory. Each memory wait cycle adds 1.
- run is ignored outside HALT. Sticky flags clear only on reset.
- Unused encodings 13–15 go to FETCH next cycle with all outputs 0.
- Reset asserted mid-instruction aborts immediately: outputs drop to 0 asynchronously, with no partial write completed after reset.

Test Plan:
- Reset held, then released with opcode = 0000 and mem_ready = 1 → states 0,1,6,7,0. reg_write = 1 and reg_dst = 1 only in state 7; ALUop = 00 in state 6.
- lw (0001) with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. mem_read with IorD = 1 held 3 cycles; mem_to_reg = 1 in 4.
- beq (0011) → BRANCH asserts pc_write_cond = 1, ALUop = 10, pc_source = 01, then FETCH. andi (0101) → EXEC_I with ALUsrcB = 11, ALUop = 01.
- Opcode 1010 → sig_illegal_op = 1 after DECODE, return to FETCH; flag stays 1 through the next 3 valid instructions.
- mem_ready held 0 in FETCH for 15 cycles → sig_mem_err = 1, state = 12. A run pulse then gives FETCH; sig_mem_err remains 1.
- Assert reset_n = 0 mid-MEMWR → mem_write drops to 0 without waiting for a clock; after release state = 0 and all flags = 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle main control FSM for the 16-bit MIPS-style core
module mc_control_fsm #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    input  logic           run,
    output logic           sig_pc_write,
    output logic           sig_pc_write_cond,
    output logic           sig_IorD,
    output logic           sig_mem_read,
    output logic           sig_mem_write,
    output logic           sig_ir_write,
    output logic           sig_mem_to_reg,
    output logic           sig_reg_write,
    output logic           sig_reg_dst,
    output logic           sig_ALUsrcA,
    output logic [1:0]     sig_ALUsrcB,
    output logic [1:0]     sig_ALUop,
    output logic [1:0]     sig_pc_source,
    output logic [3:0]     sig_state,
    output logic           sig_illegal_op,
    output logic           sig_mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_LW   = OPW'(1);
    localparam logic [OPW-1:0] OP_SW   = OPW'(2);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5);
    localparam logic [OPW-1:0] OP_J    = OPW'(6);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        WB_MEM = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        WB_R   = 4'd7,
        EXEC_I = 4'd8,
        WB_I   = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // wait_cnt only survives while stalled in a memory state; every exit clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= FETCH;
            wait_cnt       <= '0;
            sig_illegal_op <= 1'b0;
            sig_mem_err    <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH, MEMRD, MEMWR: begin
                    if (mem_ready) begin
                        case (state)
                            FETCH:   state <= DECODE;
                            MEMRD:   state <= WB_MEM;
                            default: state <= FETCH;
                        endcase
                    end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        sig_mem_err <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW, OP_ADDI: state <= MEMADR;
                        OP_R:                  state <= EXEC_R;
                        OP_ANDI:               state <= EXEC_I;
                        OP_BEQ:                state <= BRANCH;
                        OP_J:                  state <= JUMP;
                        OP_HALT:               state <= HALT;
                        default: begin
                            sig_illegal_op <= 1'b1;
                            state          <= FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    case (opcode)
                        OP_LW:   state <= MEMRD;
                        OP_SW:   state <= MEMWR;
                        OP_ADDI: state <= WB_I;
                        default: state <= FETCH;
                    endcase
                end
                EXEC_R:  state <= WB_R;
                EXEC_I:  state <= WB_I;
                HALT:    state <= run ? FETCH : HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign sig_state = state;

    // Gating on reset_n makes every enable fall the instant reset asserts
    always_comb begin
        sig_pc_write      = 1'b0;
        sig_pc_write_cond = 1'b0;
        sig_IorD          = 1'b0;
        sig_mem_read      = 1'b0;
        sig_mem_write     = 1'b0;
        sig_ir_write      = 1'b0;
        sig_mem_to_reg    = 1'b0;
        sig_reg_write     = 1'b0;
        sig_reg_dst       = 1'b0;
        sig_ALUsrcA       = 1'b0;
        sig_ALUsrcB       = 2'b00;
        sig_ALUop         = 2'b00;
        sig_pc_source     = 2'b00;
        if (reset_n) begin
            case (state)
                FETCH: begin
                    sig_mem_read = 1'b1;
                    sig_ir_write = mem_ready;
                    sig_pc_write = mem_ready;
                    sig_ALUsrcB  = 2'b01;
                    sig_ALUop    = 2'b11;
                end
                DECODE: begin
                    sig_ALUsrcB = 2'b10;
                    sig_ALUop   = 2'b11;
                end
                MEMADR: begin
                    sig_ALUsrcA = 1'b1;
                    sig_ALUsrcB = 2'b10;
                    sig_ALUop   = 2'b11;
                end
                MEMRD: begin
                    sig_mem_read = 1'b1;
                    sig_IorD     = 1'b1;
                end
                WB_MEM: begin
                    sig_reg_write  = 1'b1;
                    sig_mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    sig_mem_write = 1'b1;
                    sig_IorD      = 1'b1;
                end
                EXEC_R: begin
                    sig_ALUsrcA = 1'b1;
                end
                WB_R: begin
                    sig_reg_write = 1'b1;
                    sig_reg_dst   = 1'b1;
                end
                EXEC_I: begin
                    sig_ALUsrcA = 1'b1;
                    sig_ALUsrcB = 2'b11;
                    sig_ALUop   = 2'b01;
                end
                WB_I: begin
                    sig_reg_write = 1'b1;
                end
                BRANCH: begin
                    sig_ALUsrcA       = 1'b1;
                    sig_ALUop         = 2'b10;
                    sig_pc_write_cond = 1'b1;
                    sig_pc_source     = 2'b01;
                end
                JUMP: begin
                    sig_pc_write  = 1'b1;
                    sig_pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       run;
    logic       sig_pc_write, sig_pc_write_cond, sig_IorD, sig_mem_read, sig_mem_write;
    logic       sig_ir_write, sig_mem_to_reg, sig_reg_write, sig_reg_dst, sig_ALUsrcA;
    logic [1:0] sig_ALUsrcB, sig_ALUop, sig_pc_source;
    logic [3:0] sig_state;
    logic       sig_illegal_op, sig_mem_err;

    mc_control_fsm #(.OPW(4), .MEM_TIMEOUT(15)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .opcode            (opcode),
        .mem_ready         (mem_ready),
        .run               (run),
        .sig_pc_write      (sig_pc_write),
        .sig_pc_write_cond (sig_pc_write_cond),
        .sig_IorD          (sig_IorD),
        .sig_mem_read      (sig_mem_read),
        .sig_mem_write     (sig_mem_write),
        .sig_ir_write      (sig_ir_write),
        .sig_mem_to_reg    (sig_mem_to_reg),
        .sig_reg_write     (sig_reg_write),
        .sig_reg_dst       (sig_reg_dst),
        .sig_ALUsrcA       (sig_ALUsrcA),
        .sig_ALUsrcB       (sig_ALUsrcB),
        .sig_ALUop         (sig_ALUop),
        .sig_pc_source     (sig_pc_source),
        .sig_state         (sig_state),
        .sig_illegal_op    (sig_illegal_op),
        .sig_mem_err       (sig_mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic        mr;
        logic        rn;
        logic [3:0]  st;
        logic [15:0] outs;
        logic        ill;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    logic m_ill, m_err;

    wire [15:0] act_outs = {sig_pc_write, sig_pc_write_cond, sig_IorD, sig_mem_read,
                            sig_mem_write, sig_ir_write, sig_mem_to_reg, sig_reg_write,
                            sig_reg_dst, sig_ALUsrcA, sig_ALUsrcB, sig_ALUop, sig_pc_source};

    // Expected control word per state, bit order matches act_outs
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic mr);
        logic [15:0] o;
        o = '0;
        case (st)
            4'd0:  begin o[12] = 1'b1; o[15] = mr; o[10] = mr; o[5:4] = 2'b01; o[3:2] = 2'b11; end
            4'd1:  begin o[5:4] = 2'b10; o[3:2] = 2'b11; end
            4'd2:  begin o[6] = 1'b1; o[5:4] = 2'b10; o[3:2] = 2'b11; end
            4'd3:  begin o[12] = 1'b1; o[13] = 1'b1; end
            4'd4:  begin o[8] = 1'b1; o[9] = 1'b1; end
            4'd5:  begin o[11] = 1'b1; o[13] = 1'b1; end
            4'd6:  begin o[6] = 1'b1; end
            4'd7:  begin o[8] = 1'b1; o[7] = 1'b1; end
            4'd8:  begin o[6] = 1'b1; o[5:4] = 2'b11; o[3:2] = 2'b01; end
            4'd9:  begin o[8] = 1'b1; end
            4'd10: begin o[6] = 1'b1; o[3:2] = 2'b10; o[14] = 1'b1; o[1:0] = 2'b01; end
            4'd11: begin o[15] = 1'b1; o[1:0] = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input logic [3:0] op, input logic mr, input logic rn, input logic [3:0] st);
        exp_t e;
        e.op = op; e.mr = mr; e.rn = rn; e.st = st;
        e.outs = exp_outs(st, mr);
        e.ill = m_ill; e.err = m_err;
        sb.push_back(e);
    endtask

    // Called at a falling edge; leaves at the falling edge after the last entry
    task automatic drain(input string name);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; mem_ready = e.mr; run = e.rn;
            #1;
            checks++;
            if (sig_state !== e.st) begin
                errors++;
                $display("FAIL %s[%0d] state act=%0d exp=%0d", name, idx, sig_state, e.st);
            end
            checks++;
            if (act_outs !== e.outs) begin
                errors++;
                $display("FAIL %s[%0d] outs act=%h exp=%h", name, idx, act_outs, e.outs);
            end
            checks++;
            if ({sig_illegal_op, sig_mem_err} !== {e.ill, e.err}) begin
                errors++;
                $display("FAIL %s[%0d] flags act=%b exp=%b", name, idx,
                         {sig_illegal_op, sig_mem_err}, {e.ill, e.err});
            end
            @(negedge clk);
            idx++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opcode = 4'd0; mem_ready = 1'b1; run = 1'b0;
        m_ill = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({sig_state, act_outs, sig_illegal_op, sig_mem_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset outputs act=%h/%h exp=0", sig_state, act_outs);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_rtype();
        push(4'd0, 1, 1, 4'd0);
        push(4'd0, 1, 1, 4'd1);
        push(4'd0, 0, 1, 4'd6);
        push(4'd0, 1, 1, 4'd7);
        drain("rtype");
    endtask

    task automatic test_lw_wait();
        push(4'd1, 1, 0, 4'd0);
        push(4'd1, 1, 0, 4'd1);
        push(4'd1, 1, 0, 4'd2);
        push(4'd1, 0, 0, 4'd3);
        push(4'd1, 0, 0, 4'd3);
        push(4'd1, 1, 0, 4'd3);
        push(4'd1, 1, 0, 4'd4);
        drain("lw_wait");
    endtask

    task automatic test_beq_andi();
        push(4'd3, 1, 0, 4'd0);
        push(4'd3, 1, 0, 4'd1);
        push(4'd3, 1, 0, 4'd10);
        push(4'd5, 1, 0, 4'd0);
        push(4'd5, 1, 0, 4'd1);
        push(4'd5, 1, 0, 4'd8);
        push(4'd5, 1, 0, 4'd9);
        drain("beq_andi");
    endtask

    task automatic test_illegal();
        push(4'd10, 1, 0, 4'd0);
        push(4'd10, 1, 0, 4'd1);
        m_ill = 1'b1;
        push(4'd6, 1, 0, 4'd0);
        push(4'd6, 1, 0, 4'd1);
        push(4'd6, 1, 0, 4'd11);
        push(4'd4, 1, 0, 4'd0);
        push(4'd4, 1, 0, 4'd1);
        push(4'd4, 1, 0, 4'd2);
        push(4'd4, 1, 0, 4'd9);
        push(4'd2, 0, 0, 4'd0);
        push(4'd2, 1, 0, 4'd0);
        push(4'd2, 1, 0, 4'd1);
        push(4'd2, 1, 0, 4'd2);
        push(4'd2, 0, 0, 4'd5);
        push(4'd2, 1, 0, 4'd5);
        drain("illegal");
    endtask

    task automatic test_halt_run();
        push(4'd15, 1, 0, 4'd0);
        push(4'd15, 1, 0, 4'd1);
        push(4'd15, 1, 0, 4'd12);
        push(4'd15, 0, 0, 4'd12);
        push(4'd15, 1, 1, 4'd12);
        drain("halt_run");
    endtask

    task automatic test_fetch_timeout();
        for (int i = 0; i < 15; i++) push(4'd0, 0, 0, 4'd0);
        m_err = 1'b1;
        push(4'd0, 1, 0, 4'd12);
        push(4'd0, 0, 0, 4'd12);
        push(4'd0, 0, 1, 4'd12);
        drain("fetch_timeout");
    endtask

    task automatic test_back_to_back();
        push(4'd0, 1, 0, 4'd0);
        push(4'd0, 1, 0, 4'd1);
        push(4'd0, 1, 0, 4'd6);
        push(4'd0, 1, 0, 4'd7);
        push(4'd1, 1, 0, 4'd0);
        push(4'd1, 1, 0, 4'd1);
        push(4'd1, 1, 0, 4'd2);
        push(4'd1, 1, 0, 4'd3);
        push(4'd1, 1, 0, 4'd4);
        push(4'd2, 1, 0, 4'd0);
        push(4'd2, 1, 0, 4'd1);
        push(4'd2, 1, 0, 4'd2);
        push(4'd2, 0, 0, 4'd5);
        drain("back_to_back");
    endtask

    // Entered with the DUT stalled in MEMWR
    task automatic test_reset_mid_memwr();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (sig_mem_write !== 1'b1 || sig_state !== 4'd5) begin
            errors++;
            $display("FAIL memwr_before_reset act=%b/%0d exp=1/5", sig_mem_write, sig_state);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (sig_mem_write !== 1'b0 || act_outs !== 16'd0) begin
            errors++;
            $display("FAIL memwr_async_drop act=%h exp=0000", act_outs);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b0;
        m_ill = 1'b0; m_err = 1'b0;
        #1;
        checks++;
        if ({sig_state, sig_illegal_op, sig_mem_err} !== 6'd0) begin
            errors++;
            $display("FAIL post_reset act=%0d/%b%b exp=0/00", sig_state, sig_illegal_op, sig_mem_err);
        end
        @(negedge clk);
        push(4'd6, 1, 0, 4'd0);
        push(4'd6, 1, 0, 4'd1);
        push(4'd6, 1, 0, 4'd11);
        push(4'd6, 1, 0, 4'd0);
        drain("after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq_andi();
        test_illegal();
        test_halt_run();
        test_fetch_timeout();
        test_back_to_back();
        test_reset_mid_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
